reflet_dma: RTL

- Memory-to-memory / memory-to-peripheral copy engine: a bus initiator on the reflet system bus. Every existing peripheral only responds on that bus; this block drives it.
- Configured through a small responder register window, sized and offset like the other peripherals.
- Copies a programmable number of words from a source address to a destination address, then raises an interrupt.
- Sits beside the CPU behind an external request/grant arbiter.

---
 rtl/reflet_dma.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/reflet_dma.sv
// Word-copy DMA engine: a register window on the responder side and a
// request/grant initiator port that moves COUNT words from SRC to DST.
module reflet_dma #(
  parameter int                          wordsize       = 16,
  parameter int                          base_addr_size = 16,
  parameter logic [base_addr_size-1:0]   base_addr      = 16'hFF40,
  parameter int                          addr_width     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic [wordsize-1:0]       data_in,
  output logic [wordsize-1:0]       data_out,
  input  logic                      write_en,
  output logic                      interrupt,
  output logic                      bus_req,
  input  logic                      bus_grant,
  output logic [addr_width-1:0]     m_addr,
  output logic [wordsize-1:0]       m_data_out,
  input  logic [wordsize-1:0]       m_data_in,
  output logic                      m_write_en
);

  typedef enum logic [1:0] {IDLE, READ, LATCH, WRITE} state_t;

  state_t              state_q, state_d;
  logic [wordsize-1:0] src_q, src_d, dst_q, dst_d, count_q, count_d, buf_q, buf_d;
  logic                src_inc_q, src_inc_d, dst_inc_q, dst_inc_d, int_en_q, int_en_d;
  logic                done_q, done_d, aborted_q, aborted_d, interrupt_q, interrupt_d;

  logic [base_addr_size-1:0] offset;
  logic                      hit, busy, ctrl_wr, abort_wr;
  logic [wordsize-1:0]       count_dec;

  assign offset    = addr - base_addr;
  assign hit       = enable && (offset < base_addr_size'(4));
  assign busy      = (state_q != IDLE);
  assign ctrl_wr   = hit && write_en && (offset[1:0] == 2'd0);
  assign abort_wr  = ctrl_wr && data_in[1];
  assign count_dec = count_q - {{(wordsize-1){1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    count_d     = count_q;
    buf_d       = buf_q;
    src_inc_d   = src_inc_q;
    dst_inc_d   = dst_inc_q;
    int_en_d    = int_en_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    interrupt_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hit && write_en && !abort_wr) begin
          unique case (offset[1:0])
            2'd0: begin
              src_inc_d = data_in[2];
              dst_inc_d = data_in[3];
              int_en_d  = data_in[4];
              if (data_in[5]) done_d = 1'b0;
              if (data_in[0]) begin
                aborted_d = 1'b0;
                if (count_q != '0) begin
                  done_d  = 1'b0;
                  state_d = READ;
                end else begin
                  // Empty transfer completes on the spot without touching the bus.
                  done_d      = 1'b1;
                  interrupt_d = data_in[4];
                end
              end
            end
            2'd1: src_d   = data_in;
            2'd2: dst_d   = data_in;
            2'd3: count_d = data_in;
          endcase
        end
      end
      READ: begin
        if (bus_grant) state_d = LATCH;
      end
      LATCH: begin
        buf_d   = m_data_in;
        state_d = WRITE;
      end
      WRITE: begin
        if (bus_grant) begin
          src_d   = src_q + {{(wordsize-1){1'b0}}, src_inc_q};
          dst_d   = dst_q + {{(wordsize-1){1'b0}}, dst_inc_q};
          count_d = count_dec;
          if (count_dec == '0) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            interrupt_d = int_en_q;
          end else begin
            state_d = READ;
          end
        end
      end
    endcase

    // Abort overrides the sequencing but lets a granted write's updates stand.
    if (abort_wr) begin
      state_d     = IDLE;
      aborted_d   = 1'b1;
      done_d      = done_q;
      interrupt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      count_q     <= '0;
      buf_q       <= '0;
      src_inc_q   <= 1'b0;
      dst_inc_q   <= 1'b0;
      int_en_q    <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      count_q     <= count_d;
      buf_q       <= buf_d;
      src_inc_q   <= src_inc_d;
      dst_inc_q   <= dst_inc_d;
      int_en_q    <= int_en_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign interrupt  = interrupt_q;
  assign bus_req    = busy;
  assign m_write_en = (state_q == WRITE) && bus_grant;
  assign m_addr     = (state_q == WRITE) ? addr_width'(dst_q) : addr_width'(src_q);
  assign m_data_out = buf_q;

  always_comb begin
    data_out = '0;
    if (hit) begin
      unique case (offset[1:0])
        2'd0: begin
          data_out[0] = busy;
          data_out[2] = src_inc_q;
          data_out[3] = dst_inc_q;
          data_out[4] = int_en_q;
          data_out[5] = done_q;
          data_out[6] = aborted_q;
        end
        2'd1: data_out = src_q;
        2'd2: data_out = dst_q;
        2'd3: data_out = count_q;
      endcase
    end
  end

endmodule
